// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - register file with two read ports, one write port and a busy scoreboard
// Busy bits mark registers reserved by an in-flight producer; writes retire them.
module regfile_scoreboard #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 2,
  parameter logic [(2**ADDR_W)*DATA_W-1:0] RESET_VALS = {4'd0, 4'd3, 4'd0, 4'd2},
  parameter bit ZERO_REG = 1'b0,
  parameter bit BYPASS = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      rd_addr,
  input  logic [DATA_W-1:0]      rd_data,
  input  logic [ADDR_W-1:0]      rs1_addr,
  input  logic [ADDR_W-1:0]      rs2_addr,
  output logic [DATA_W-1:0]      rs1_data,
  output logic [DATA_W-1:0]      rs2_data,
  output logic                   rs1_ready,
  output logic                   rs2_ready,
  input  logic                   alloc_valid,
  input  logic [ADDR_W-1:0]      alloc_addr,
  output logic                   alloc_ready,
  output logic [(2**ADDR_W)-1:0] busy_mask
);

  localparam int NREGS = 2**ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [NREGS-1:0]  busy_q, busy_d;
  logic              wr_en, zr_alloc, alloc_fire;

  assign wr_en      = we && !(ZERO_REG && (rd_addr == '0));
  assign zr_alloc   = ZERO_REG && (alloc_addr == '0);
  assign alloc_ready = zr_alloc || !busy_q[alloc_addr] || (we && (rd_addr == alloc_addr));
  assign alloc_fire = alloc_valid && alloc_ready && !zr_alloc;

  // Set is applied after clear so a same-edge alloc reserves the new producer.
  always_comb begin
    busy_d = busy_q;
    if (wr_en)
      busy_d[rd_addr] = 1'b0;
    if (alloc_fire)
      busy_d[alloc_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        if (ZERO_REG && (i == 0))
          regs_q[i] <= '0;
        else
          regs_q[i] <= RESET_VALS[i*DATA_W +: DATA_W];
      end
      busy_q <= '0;
    end else begin
      if (wr_en)
        regs_q[rd_addr] <= rd_data;
      busy_q <= busy_d;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a);
    if (ZERO_REG && (a == '0))
      return '0;
    else if (BYPASS && wr_en && (rd_addr == a))
      return rd_data;
    else
      return regs_q[a];
  endfunction

  function automatic logic ready_port(input logic [ADDR_W-1:0] a);
    return !busy_q[a] || (BYPASS && we && (rd_addr == a));
  endfunction

  assign rs1_data  = read_port(rs1_addr);
  assign rs2_data  = read_port(rs2_addr);
  assign rs1_ready = ready_port(rs1_addr);
  assign rs2_ready = ready_port(rs2_addr);
  assign busy_mask = busy_q;

endmodule
